// File: rtl/divclk_period_meter.sv
// divclk_period_meter
//   Measures the period of a slow square wave (e.g. a ripple clock divider
//   output) in chip-clock cycles. It counts the cycles between successive
//   synchronized rising edges of sig and latches the count into a 16-bit
//   period register. The register is read out one byte at a time, or a
//   status byte is shown instead.
//
// Ports
//   io_in[0]   clk        rising-edge clock
//   io_in[1]   rst        asynchronous, active-high reset
//   io_in[2]   sig        measured signal, asynchronous to clk
//   io_in[3]   byte_sel   0 = period[7:0], 1 = period[15:8]
//   io_in[4]   status_sel 1 = status byte, overrides byte_sel
//   io_in[5]   clr        synchronous clear of valid and ovf
//   io_in[7:6] unused
//   io_out     selected period byte, or
//              {valid, ovf, timeout, measuring, edge_count[3:0]}
module divclk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        ARM     = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic clk;
    logic rst;
    logic sig;
    logic byte_sel;
    logic status_sel;
    logic clr;
    logic unused_io;

    assign clk        = io_in[0];
    assign rst        = io_in[1];
    assign sig        = io_in[2];
    assign byte_sel   = io_in[3];
    assign status_sel = io_in[4];
    assign clr        = io_in[5];
    assign unused_io  = &{1'b0, io_in[7:6]};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_q;
    logic                   sync_out;
    logic                   rise;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] period_q,   period_d;
    logic             valid_q,    valid_d;
    logic             ovf_q,      ovf_d;
    logic             timeout_q,  timeout_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;

    // Stage 0: synchronizer chain plus one delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            d_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            d_q    <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~d_q;

    // Stage 1: measurement FSM and result registers
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        timeout_d  = timeout_q;
        edge_cnt_d = edge_cnt_q;

        // clr is applied first so a latch in the same cycle overrides it.
        if (clr) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end

        case (state_q)
            ARM: begin
                cnt_d = '0;
                if (rise) begin
                    state_d    = MEASURE;
                    cnt_d      = CNT_ONE;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    valid_d    = 1'b1;
                    period_d   = cnt_q;
                    if (timeout_q) begin
                        ovf_d    = 1'b1;
                        period_d = CNT_MAX;
                    end
                    timeout_d  = 1'b0;
                    cnt_d      = CNT_ONE;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                end else if (cnt_q == CNT_MAX) begin
                    // Saturate; the pending latch will report overflow.
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARM;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            timeout_q  <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            timeout_q  <= timeout_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Output select is purely combinational from registered state.
    always_comb begin
        if (status_sel) begin
            io_out = {valid_q, ovf_q, timeout_q, (state_q == MEASURE), edge_cnt_q};
        end else if (byte_sel) begin
            io_out = period_q[15:8];
        end else begin
            io_out = period_q[7:0];
        end
    end

endmodule

// File: tb/tb_divclk_period_meter.sv
// Bench for divclk_period_meter: directed sig waveforms; each check pushes
// the expected io_out byte into a queue and a separate monitor pops and
// compares on the falling clock edge.
module tb_divclk_period_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sig = 1'b0;
    logic       byte_sel = 1'b0;
    logic       status_sel = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {2'b10, clr, status_sel, byte_sel, sig, rst, clk};

    divclk_period_meter #(
        .CNT_W      (16),
        .SYNC_STAGES(2)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    // Monitor: compares io_out against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (io_out !== e) begin
                n_fail++;
                $display("FAIL %s: io_out=0x%02h expected 0x%02h at %0t", nm, io_out, e, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Select the view, queue the expected byte, and give the monitor one cycle.
    task automatic expect_out(input string nm, input logic bs, input logic ss,
                              input logic [7:0] e);
        byte_sel   = bs;
        status_sel = ss;
        name_q.push_back(nm);
        exp_q.push_back(e);
        tick(1);
    endtask

    // One period of a square wave: one rising edge at the call start.
    task automatic square(input int p);
        sig = 1'b1;
        tick(p / 2);
        sig = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic do_reset();
        sig = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #(100_000 * 10);
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);

        // Reset state: every select view reads zero while reset is held.
        rst = 1'b1;
        expect_out("rst_byte0",  1'b0, 1'b0, 8'h00);
        expect_out("rst_byte1",  1'b1, 1'b0, 8'h00);
        expect_out("rst_status", 1'b0, 1'b1, 8'h00);
        rst = 1'b0;
        tick(1);

        // Period 100 square wave, 3 rises.
        do_reset();
        for (int i = 0; i < 3; i++) square(100);
        expect_out("p100_byte0",  1'b0, 1'b0, 8'h64);
        expect_out("p100_byte1",  1'b1, 1'b0, 8'h00);
        expect_out("p100_status", 1'b0, 1'b1, 8'h93);

        // Divide-by-8192 stimulus, two rises.
        do_reset();
        for (int i = 0; i < 2; i++) square(8192);
        expect_out("div_byte1",  1'b1, 1'b0, 8'h20);
        expect_out("div_byte0",  1'b0, 1'b0, 8'h00);
        expect_out("div_status", 1'b0, 1'b1, 8'h92);

        // Timeout: arm, hold low past 0xFFFF counts, then one rise.
        do_reset();
        square(4);
        tick(65600);
        expect_out("to_status",    1'b0, 1'b1, 8'h31);
        square(4);
        expect_out("ovf_status",   1'b0, 1'b1, 8'hD2);
        expect_out("ovf_byte0",    1'b0, 1'b0, 8'hFF);
        expect_out("ovf_byte1",    1'b1, 1'b0, 8'hFF);

        // clr alone drops valid/ovf but keeps period.
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        expect_out("clr_status", 1'b0, 1'b1, 8'h12);
        expect_out("clr_byte0",  1'b0, 1'b0, 8'hFF);

        // clr in the same cycle as a rise: latch wins. Gap since last rise is 10.
        sig = 1'b1;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        sig = 1'b0;
        tick(2);
        expect_out("clr_rise_status", 1'b0, 1'b1, 8'h93);
        expect_out("clr_rise_byte0",  1'b0, 1'b0, 8'h0A);

        // 17 rises of period 10: edge_count wraps to 1, then reset mid-period.
        do_reset();
        for (int i = 0; i < 17; i++) square(10);
        expect_out("wrap_status", 1'b0, 1'b1, 8'h91);
        expect_out("wrap_byte0",  1'b0, 1'b0, 8'h0A);
        tick(2);
        rst = 1'b1;
        expect_out("midrst_byte0",  1'b0, 1'b0, 8'h00);
        expect_out("midrst_byte1",  1'b1, 1'b0, 8'h00);
        expect_out("midrst_status", 1'b0, 1'b1, 8'h00);
        rst = 1'b0;
        tick(1);
        square(10);
        expect_out("rearm_status", 1'b0, 1'b1, 8'h11);
        expect_out("rearm_byte0",  1'b0, 1'b0, 8'h00);

        // Minimum period of 2, then an unsampled glitch.
        do_reset();
        for (int i = 0; i < 3; i++) square(2);
        tick(3);
        expect_out("p2_byte0",  1'b0, 1'b0, 8'h02);
        expect_out("p2_status", 1'b0, 1'b1, 8'h93);
        sig = 1'b1;
        #2;
        sig = 1'b0;
        tick(5);
        expect_out("glitch_status", 1'b0, 1'b1, 8'h93);
        expect_out("glitch_byte0",  1'b0, 1'b0, 8'h02);

        tick(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
